// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
//   Single-clock FIFO used as a rate-decoupling buffer between a producer and
//   a consumer in the same clock domain.
//
//   Features:
//     - Any depth of 2 or more; the depth does not have to be a power of two.
//     - Read mode chosen at elaboration time:
//         FWFT = 0 : standard mode. The read is registered.
//         FWFT = 1 : first-word-fall-through. The head word is always shown.
//     - Programmable almost-full and almost-empty thresholds.
//     - Occupancy count output.
//     - Synchronous flush.
//     - Sticky overflow and underflow error flags.
//
// Parameters
//   WIDTH     : data width in bits.
//   DEPTH     : number of entries.
//   FWFT      : read mode (0 = standard, 1 = first-word-fall-through).
//   AF_THRESH : almost_full is high while count >= AF_THRESH.
//   AE_THRESH : almost_empty is high while count <= AE_THRESH.
//
// Ports
//   clk          : single clock, rising edge.
//   reset        : synchronous, active-high. Has priority over flush.
//   flush        : synchronous clear of pointers and count.
//                  It overrides w_en and r_en in the same cycle.
//   data_in      : write data.
//   w_en         : write request.
//   r_en         : read request (pop).
//   data_out     : read data.
//   valid        : data_out holds a valid word.
//   full, empty  : occupancy status flags.
//   almost_full  : threshold flag.
//   almost_empty : threshold flag.
//   count        : current occupancy, 0..DEPTH.
//   overflow     : sticky error flag, cleared only by reset.
//   underflow    : sticky error flag, cleared only by reset.
module sync_fifo_fwft #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       w_en,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] w_ptr_q, w_ptr_d;
  logic [AW-1:0] r_ptr_q, r_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_ok, rd_ok;

  // All status outputs are decoded from the registered count, so there is
  // no combinational path from the request inputs to any output.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // A read on an empty FIFO is never accepted, even with a write alongside.
    rd_ok = r_en && !empty && !flush;
    // A write is accepted when full only if a read frees a slot in the same
    // cycle. At full, w_ptr equals r_ptr, so the write lands in the slot
    // the read is vacating.
    wr_ok = w_en && (!full || rd_ok) && !flush;

    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (w_en && full && !rd_ok && !flush);
    underflow_d = underflow_q | (r_en && empty && !flush);

    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      // Explicit wrap at DEPTH-1, so non-power-of-two depths work.
      if (wr_ok) begin
        w_ptr_d = (w_ptr_q == PTR_LAST) ? '0 : w_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        r_ptr_d = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset. Reset and flush only move the pointers.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[w_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] data_out_q, data_out_d;
      logic             valid_q, valid_d;

      // Registered read. valid pulses for one cycle per accepted read.
      // data_out holds its last word between reads.
      always_comb begin
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        if (rd_ok) begin
          data_out_d = mem[r_ptr_q];
          valid_d    = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          data_out_q <= '0;
          valid_q    <= 1'b0;
        end else begin
          data_out_q <= data_out_d;
          valid_q    <= valid_d;
        end
      end

      assign data_out = data_out_q;
      assign valid    = valid_q;
    end else begin : g_fwft
      // The head word is always presented. r_en acknowledges it.
      // Output is forced to zero when empty, so stale memory never shows.
      assign data_out = empty ? '0 : mem[r_ptr_q];
      assign valid    = !empty;
    end
  endgenerate

endmodule
